// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// uart_fifo : memory-mapped 8N1 UART, TX byte FIFO with a programmable divider.
//             Optional receiver with a one-byte holding register (`UART_RX_EN).
// Revision  : 1.0
// ============================================================================
module uart_fifo #(
   parameter int unsigned DIV_RESET  = 104,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [3:0]  ADDR_BASE  = 4'h4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [2:0]  write_enable,
   input  logic [23:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        uart_txd,
   input  logic        uart_rxd,
   output logic        uart_irq
);
   localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      DIV_MIN  = 16'd4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic [3:0]  reg_off;
   logic        reg_hit, bus_wr, bus_rd, wr_tx, wr_div;
   logic [31:0] rdata;

   // Register offset relative to ADDR_BASE; wraps mod 16.
   assign reg_off = addr[3:0] - ADDR_BASE;
   assign reg_hit = (reg_off[3:2] == 2'b00);
   assign bus_wr  = en & write_enable[2];
   assign bus_rd  = en & (write_enable == 3'b000);
   assign wr_tx   = bus_wr & reg_hit & (reg_off[1:0] == 2'd0);
   assign wr_div  = bus_wr & reg_hit & (reg_off[1:0] == 2'd3);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push, pop, fifo_empty, fifo_full;
   logic [15:0]      div_q;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign push       = wr_tx & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= data_in[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         div_q   <= 16'(DIV_RESET);
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
         if (wr_div) div_q <= (data_in[15:0] < DIV_MIN) ? DIV_MIN : data_in[15:0];
      end
   end

   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_last, tx_busy;

   assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);
   assign tx_busy = ~fifo_empty | (tx_state_q != TX_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= 16'(DIV_RESET);
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   // The divisor is sampled only when a frame is launched.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      pop        = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               tx_state_d = TX_START;
               tx_shift_d = mem_q[rptr_q];
               tx_div_d   = div_q;
            end
         end
         TX_START: begin
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b1, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_last) begin
               tx_cnt_d = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  tx_state_d = TX_START;
                  tx_shift_d = mem_q[rptr_q];
                  tx_div_d   = div_q;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      uart_txd = 1'b1;
      case (tx_state_q)
         TX_START: uart_txd = 1'b0;
         TX_DATA:  uart_txd = tx_shift_q[0];
         default:  uart_txd = 1'b1;
      endcase
   end

   logic       rx_valid, rx_ovr, rx_ferr;
   logic [7:0] rx_byte;
   logic       unused_ok;

`ifdef UART_RX_EN
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q;
   logic        sync1_q, sync2_q, sync3_q;
   logic        rx_valid_q, rx_ovr_q, rx_ferr_q;
   logic        rx_done, rx_ferr_set, rd_rxdata, wr_status, rx_last, rx_half;

   assign rd_rxdata = bus_rd & reg_hit & (reg_off[1:0] == 2'd2);
   assign wr_status = bus_wr & reg_hit & (reg_off[1:0] == 2'd1);
   assign rx_last   = (rx_cnt_q == rx_div_q - 16'd1);
   // State entry already lags the line by one clock, hence the -1.
   assign rx_half   = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         sync3_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= 16'(DIV_RESET);
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         sync1_q    <= uart_rxd;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         if (rd_rxdata)                rx_valid_q <= 1'b0;
         if (wr_status && data_in[3]) rx_ovr_q   <= 1'b0;
         if (wr_status && data_in[4]) rx_ferr_q  <= 1'b0;
         if (rx_ferr_set)             rx_ferr_q  <= 1'b1;
         if (rx_done) begin
            if (rx_valid_q) begin
               rx_ovr_q <= 1'b1;
            end else begin
               rx_byte_q  <= rx_shift_q;
               rx_valid_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + 16'd1;
      rx_div_d    = rx_div_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_done     = 1'b0;
      rx_ferr_set = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (sync3_q && !sync2_q) begin
               rx_state_d = RX_START;
               rx_div_d   = div_q;
            end
         end
         RX_START: begin
            if (rx_half) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_last) begin
               rx_cnt_d   = '0;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_last) begin
               rx_cnt_d    = '0;
               rx_done     = sync2_q;
               rx_ferr_set = ~sync2_q;
               rx_state_d  = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign rx_valid  = rx_valid_q;
   assign rx_ovr    = rx_ovr_q;
   assign rx_ferr   = rx_ferr_q;
   assign rx_byte   = rx_byte_q;
   assign unused_ok = ^{addr[23:4], data_in[31:16]};
`else
   assign rx_valid  = 1'b0;
   assign rx_ovr    = 1'b0;
   assign rx_ferr   = 1'b0;
   assign rx_byte   = 8'h00;
   assign unused_ok = ^{addr[23:4], data_in[31:16], uart_rxd};
`endif

   always_comb begin
      rdata = 32'd0;
      case (reg_off[1:0])
         2'd1:    rdata = {27'd0, rx_ferr, rx_ovr, rx_valid, fifo_full, tx_busy};
         2'd2:    rdata = {24'd0, rx_byte};
         2'd3:    rdata = {16'd0, div_q};
         default: rdata = 32'd0;
      endcase
   end

   assign data_out = (bus_rd & reg_hit) ? rdata : 32'hzzzz_zzzz;
   assign uart_irq = rx_valid | ~tx_busy;

endmodule
`default_nettype wire
